regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
Parametrised MIPS general-purpose register file with two combinational read ports, one clocked write port with byte enables, and write-to-read bypass. It adds a per-register pending-write scoreboard so decode can stall on load-use hazards. It sits between the decode stage (reads, busy checks, busy set on load issue) and the writeback stage (writes).

Parameters:
DATA_W, 32, register width in bits; must be a multiple of 8.
ADDR_W, 5, register index width; depth = 2**ADDR_W.
SP_IDX, 29, index of the stack-pointer register.
SP_INIT, 10000, reset value of register SP_IDX.
BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return stored value only.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
rd_addr1  in  ADDR_W  read port 1 index.
rd_addr2  in  ADDR_W  read port 2 index.
rd_data1  out  DATA_W  read port 1 data, combinational.
rd_data2  out  DATA_W  read port 2 data, combinational.
rd_busy1  out  1  register rd_addr1 has a pending write.
rd_busy2  out  1  register rd_addr2 has a pending write.
we  in  1  write enable.
wr_addr  in  ADDR_W  write index.
wr_data  in  DATA_W  write data.
wr_be  in  DATA_W/8  byte enables; bit i covers wr_data[8i+7:8i].
busy_set  in  1  mark busy_addr as pending (load issued).
busy_addr  in  ADDR_W  index to mark.
flush  in  1  clear all busy bits (pipeline flush).
busy_any  out  1  OR of all busy bits.

Behaviour:
- Reset (rst_n low, async): every register = 0 except reg[SP_IDX] = SP_INIT; all busy bits = 0. Reads during reset return these values; busy_any = 0; rd_busy* = 0.
- Register 0: always reads 0, never busy; writes to and busy_set on index 0 are ignored.
- Write: at rising edge, when we=1 and wr_addr!=0, reg[wr_addr] byte i <= wr_data byte i for each wr_be[i]=1; other bytes unchanged. we=1 with wr_be=0 changes no data but still clears busy.
- Read: rd_dataN = 0 when rd_addrN=0. Otherwise, if BYPASS=1 and we=1 and wr_addrN... precisely: if BYPASS=1, we=1 and wr_addr==rd_addrN, rd_dataN = stored value merged with wr_data under wr_be (identical to the post-edge value). Otherwise rd_dataN = reg[rd_addrN]. Both ports are independent; both may hit the bypass in the same cycle.
- Scoreboard, per register, at rising edge, priority high to low:
  1. flush=1: all busy <= 0 (a same-cycle busy_set is discarded; the write still occurs).
  2. busy_set=1 and busy_addr!=0: busy[busy_addr] <= 1. This wins over a same-cycle write to the same index; that write's data is still stored.
  3. we=1 and wr_addr!=0: busy[wr_addr] <= 0.
- rd_busyN = busy[rd_addrN], forced 0 for index 0. When BYPASS=1, rd_busyN is also forced 0 if we=1 and wr_addr==rd_addrN (data is valid via bypass). When BYPASS=0, rd_busyN is not masked.
- busy_any reflects registered busy bits only (no bypass masking).
- Latency: write data is visible in the storage array one edge after we. Busy bits update one edge after set, clear or flush.
- Reset asserted mid-operation overrides all pending writes and busy updates immediately.

Test Plan:
- Reset: release rst_n; read addr 29 and addr 5 -> rd_data1=10000, rd_data2=0, busy_any=0.
- Write/bypass: we=1, wr_addr=3, wr_data=0xDEADBEEF, wr_be=4'hF, rd_addr1=3 in same cycle -> rd_data1=0xDEADBEEF combinationally. After the edge with we=0 -> still 0xDEADBEEF. Repeat with BYPASS=0 -> old value 0 before the edge.
- Byte enables: reg3=0xDEADBEEF; write 0x11223344 with wr_be=4'b0101 -> reg3=0xDE22BE44.
- Zero register: write 0xFFFFFFFF to addr 0 and busy_set addr 0 -> rd_data=0, rd_busy=0, busy_any=0.
- Scoreboard: busy_set addr 7 -> next cycle rd_busy1(7)=1, busy_any=1. Write addr 7 -> rd_busy1=0 during the write cycle (bypass), busy[7]=0 after. Simultaneous busy_set 7 and write 7 -> busy[7]=1 and data stored.
- Flush/reset mid-op: busy bits set on 4 and 9, then flush=1 with busy_set 12 -> all busy=0. Separately, assert rst_n low between edges while we=1 -> regs return to reset values immediately and the write is lost.

Source files
------------

// File: rtl/regfile_sb_if.sv
// Decode/writeback bundle for the scoreboarded register file.
// Master = pipeline stages, slave = register file.
interface regfile_sb_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic [ADDR_W-1:0]   rd_addr1;
    logic [ADDR_W-1:0]   rd_addr2;
    logic [DATA_W-1:0]   rd_data1;
    logic [DATA_W-1:0]   rd_data2;
    logic                rd_busy1;
    logic                rd_busy2;
    logic                we;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic [DATA_W/8-1:0] wr_be;
    logic                busy_set;
    logic [ADDR_W-1:0]   busy_addr;
    logic                flush;
    logic                busy_any;

    modport master (
        output rd_addr1, rd_addr2, we, wr_addr, wr_data, wr_be,
               busy_set, busy_addr, flush,
        input  rd_data1, rd_data2, rd_busy1, rd_busy2, busy_any
    );

    modport slave (
        input  rd_addr1, rd_addr2, we, wr_addr, wr_data, wr_be,
               busy_set, busy_addr, flush,
        output rd_data1, rd_data2, rd_busy1, rd_busy2, busy_any
    );
endinterface

// File: rtl/regfile_sb.sv
// MIPS GPR file: 2 combinational read ports, byte-enabled write port with
// optional write-to-read bypass, and a per-register pending-load scoreboard.
module regfile_sb #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned SP_IDX  = 29,
    parameter int unsigned SP_INIT = 10000,
    parameter bit          BYPASS  = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    regfile_sb_if.slave  bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned NB    = DATA_W / 8;

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]  r_busy;

    logic [DATA_W-1:0] w_wr_merged;
    logic              w_wr_valid;
    logic              w_hit1;
    logic              w_hit2;
    logic [DATA_W-1:0] w_rd_data1;
    logic [DATA_W-1:0] w_rd_data2;
    logic              w_rd_busy1;
    logic              w_rd_busy2;

    function automatic logic [DATA_W-1:0] merge_be(
        input logic [DATA_W-1:0] old_v,
        input logic [DATA_W-1:0] new_v,
        input logic [NB-1:0]     be
    );
        logic [DATA_W-1:0] m;
        m = old_v;
        for (int i = 0; i < int'(NB); i++) begin
            if (be[i]) m[8*i +: 8] = new_v[8*i +: 8];
        end
        return m;
    endfunction

    // Post-edge value of the write target; doubles as the bypass value.
    always_comb begin
        w_wr_valid  = bus.we && (bus.wr_addr != '0);
        w_wr_merged = merge_be(r_regs[bus.wr_addr], bus.wr_data, bus.wr_be);
    end

    // Storage; index 0 is never written so it stays at its reset zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_regs[i] <= (i == SP_IDX) ? DATA_W'(SP_INIT) : '0;
            end
        end else if (w_wr_valid) begin
            r_regs[bus.wr_addr] <= w_wr_merged;
        end
    end

    // Scoreboard: flush beats set, set beats the writeback clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else if (bus.flush) begin
            r_busy <= '0;
        end else begin
            if (w_wr_valid) r_busy[bus.wr_addr] <= 1'b0;
            if (bus.busy_set && (bus.busy_addr != '0)) r_busy[bus.busy_addr] <= 1'b1;
        end
    end

    always_comb begin
        w_hit1 = BYPASS && bus.we && (bus.wr_addr == bus.rd_addr1);
        w_hit2 = BYPASS && bus.we && (bus.wr_addr == bus.rd_addr2);

        w_rd_data1 = r_regs[bus.rd_addr1];
        w_rd_busy1 = r_busy[bus.rd_addr1];
        if (bus.rd_addr1 == '0) begin
            w_rd_data1 = '0;
            w_rd_busy1 = 1'b0;
        end else if (w_hit1) begin
            w_rd_data1 = w_wr_merged;
            w_rd_busy1 = 1'b0;
        end

        w_rd_data2 = r_regs[bus.rd_addr2];
        w_rd_busy2 = r_busy[bus.rd_addr2];
        if (bus.rd_addr2 == '0) begin
            w_rd_data2 = '0;
            w_rd_busy2 = 1'b0;
        end else if (w_hit2) begin
            w_rd_data2 = w_wr_merged;
            w_rd_busy2 = 1'b0;
        end
    end

    assign bus.rd_data1 = w_rd_data1;
    assign bus.rd_data2 = w_rd_data2;
    assign bus.rd_busy1 = w_rd_busy1;
    assign bus.rd_busy2 = w_rd_busy2;
    assign bus.busy_any = |r_busy;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: bypass and non-bypass instances driven in lockstep
// against a behavioural register/scoreboard model, plus directed pins.
module tb_regfile_sb;
    logic        clk;
    logic        rst_n;
    logic [4:0]  rd_addr1, rd_addr2, wr_addr, busy_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        we, busy_set, flush;

    int n_checks = 0;
    int n_err    = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_busy;

    regfile_sb_if #(.DATA_W(32), .ADDR_W(5)) bus_b ();
    regfile_sb_if #(.DATA_W(32), .ADDR_W(5)) bus_n ();

    assign bus_b.rd_addr1 = rd_addr1;  assign bus_n.rd_addr1 = rd_addr1;
    assign bus_b.rd_addr2 = rd_addr2;  assign bus_n.rd_addr2 = rd_addr2;
    assign bus_b.we       = we;        assign bus_n.we       = we;
    assign bus_b.wr_addr  = wr_addr;   assign bus_n.wr_addr  = wr_addr;
    assign bus_b.wr_data  = wr_data;   assign bus_n.wr_data  = wr_data;
    assign bus_b.wr_be    = wr_be;     assign bus_n.wr_be    = wr_be;
    assign bus_b.busy_set = busy_set;  assign bus_n.busy_set = busy_set;
    assign bus_b.busy_addr= busy_addr; assign bus_n.busy_addr= busy_addr;
    assign bus_b.flush    = flush;     assign bus_n.flush    = flush;

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .SP_IDX(29), .SP_INIT(10000), .BYPASS(1'b1))
        u_dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
    regfile_sb #(.DATA_W(32), .ADDR_W(5), .SP_IDX(29), .SP_INIT(10000), .BYPASS(1'b0))
        u_dut_n (.clk(clk), .rst_n(rst_n), .bus(bus_n));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] apply_be(input logic [31:0] old_v, input logic [31:0] d,
                                             input logic [3:0] be);
        logic [31:0] v;
        v = old_v;
        for (int b = 0; b < 4; b++) if (be[b]) v[8*b +: 8] = d[8*b +: 8];
        return v;
    endfunction

    function automatic logic [31:0] exp_data(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 32'd0;
        if (byp && we && wr_addr == a) return apply_be(m_regs[a], wr_data, wr_be);
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 1'b0;
        if (byp && we && wr_addr == a) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 32; r++) m_regs[r] = (r == 29) ? 32'd10000 : 32'd0;
        m_busy = 32'd0;
    endtask

    // Reference model: array of registers plus a busy vector, edge semantics.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            logic [31:0] nb;
            for (int r = 1; r < 32; r++) begin
                if (flush)                                   nb[r] = 1'b0;
                else if (busy_set && busy_addr == 5'(r))     nb[r] = 1'b1;
                else if (we && wr_addr == 5'(r))             nb[r] = 1'b0;
                else                                         nb[r] = m_busy[r];
            end
            nb[0] = 1'b0;
            if (we && wr_addr != 5'd0) m_regs[wr_addr] = apply_be(m_regs[wr_addr], wr_data, wr_be);
            m_busy = nb;
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("b_rd_data1", bus_b.rd_data1, exp_data(rd_addr1, 1'b1));
            check("b_rd_data2", bus_b.rd_data2, exp_data(rd_addr2, 1'b1));
            check("b_rd_busy1", 32'(bus_b.rd_busy1), 32'(exp_busy(rd_addr1, 1'b1)));
            check("b_rd_busy2", 32'(bus_b.rd_busy2), 32'(exp_busy(rd_addr2, 1'b1)));
            check("b_busy_any", 32'(bus_b.busy_any), 32'(|m_busy));
            check("n_rd_data1", bus_n.rd_data1, exp_data(rd_addr1, 1'b0));
            check("n_rd_data2", bus_n.rd_data2, exp_data(rd_addr2, 1'b0));
            check("n_rd_busy1", 32'(bus_n.rd_busy1), 32'(exp_busy(rd_addr1, 1'b0)));
            check("n_rd_busy2", 32'(bus_n.rd_busy2), 32'(exp_busy(rd_addr2, 1'b0)));
            check("n_busy_any", 32'(bus_n.busy_any), 32'(|m_busy));
        end
    end

    task automatic idle();
        we = 1'b0; wr_addr = 5'd0; wr_data = 32'd0; wr_be = 4'd0;
        busy_set = 1'b0; busy_addr = 5'd0; flush = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] rnd_addr();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r == 8) return 5'd29;
        if (r == 9) return 5'($urandom);
        return 5'(r);
    endfunction

    initial begin
        rst_n = 1'b0;
        idle();
        rd_addr1 = 5'd0; rd_addr2 = 5'd0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset values
        rd_addr1 = 5'd29; rd_addr2 = 5'd5;
        #1;
        check("rst_sp", bus_b.rd_data1, 32'd10000);
        check("rst_r5", bus_b.rd_data2, 32'd0);
        check("rst_busy_any", 32'(bus_b.busy_any), 32'd0);

        // Full write with same-cycle read
        cyc();
        we = 1'b1; wr_addr = 5'd3; wr_data = 32'hDEADBEEF; wr_be = 4'hF; rd_addr1 = 5'd3;
        #1;
        check("byp_same_cycle", bus_b.rd_data1, 32'hDEADBEEF);
        check("nobyp_same_cycle", bus_n.rd_data1, 32'd0);
        cyc(); idle(); #1;
        check("byp_after", bus_b.rd_data1, 32'hDEADBEEF);
        check("nobyp_after", bus_n.rd_data1, 32'hDEADBEEF);

        // Byte-enable merge
        we = 1'b1; wr_addr = 5'd3; wr_data = 32'h11223344; wr_be = 4'b0101;
        cyc(); idle(); #1;
        check("be_merge_b", bus_b.rd_data1, 32'hDE22BE44);
        check("be_merge_n", bus_n.rd_data1, 32'hDE22BE44);

        // Register zero
        we = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF; wr_be = 4'hF;
        busy_set = 1'b1; busy_addr = 5'd0; rd_addr1 = 5'd0;
        #1;
        check("r0_data_wr", bus_b.rd_data1, 32'd0);
        check("r0_busy_wr", 32'(bus_b.rd_busy1), 32'd0);
        cyc(); idle(); #1;
        check("r0_data_after", bus_b.rd_data1, 32'd0);
        check("r0_busy_any", 32'(bus_b.busy_any), 32'd0);

        // Scoreboard set / bypass-masked clear / set-beats-clear
        busy_set = 1'b1; busy_addr = 5'd7; rd_addr1 = 5'd7;
        cyc(); idle(); #1;
        check("sb_set_busy1", 32'(bus_b.rd_busy1), 32'd1);
        check("sb_set_any", 32'(bus_b.busy_any), 32'd1);
        we = 1'b1; wr_addr = 5'd7; wr_data = 32'h5; wr_be = 4'hF;
        #1;
        check("sb_mask_b", 32'(bus_b.rd_busy1), 32'd0);
        check("sb_nomask_n", 32'(bus_n.rd_busy1), 32'd1);
        cyc(); idle(); #1;
        check("sb_cleared", 32'(bus_b.rd_busy1), 32'd0);
        check("sb_cleared_any", 32'(bus_b.busy_any), 32'd0);
        busy_set = 1'b1; busy_addr = 5'd7;
        we = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5; wr_be = 4'hF;
        cyc(); idle(); #1;
        check("sb_set_wins", 32'(bus_b.rd_busy1), 32'd1);
        check("sb_set_wins_data", bus_b.rd_data1, 32'hA5A5A5A5);

        // Flush discards concurrent set
        busy_set = 1'b1; busy_addr = 5'd4;
        cyc(); busy_addr = 5'd9;
        cyc(); idle(); #1;
        check("fl_pre_any", 32'(bus_b.busy_any), 32'd1);
        flush = 1'b1; busy_set = 1'b1; busy_addr = 5'd12;
        cyc(); idle(); rd_addr1 = 5'd12; rd_addr2 = 5'd4; #1;
        check("fl_any", 32'(bus_b.busy_any), 32'd0);
        check("fl_busy12", 32'(bus_b.rd_busy1), 32'd0);
        check("fl_busy4", 32'(bus_b.rd_busy2), 32'd0);

        // Asynchronous reset during a write
        cyc();
        we = 1'b1; wr_addr = 5'd3; wr_data = 32'h12345678; wr_be = 4'hF;
        rd_addr1 = 5'd29; rd_addr2 = 5'd7;
        #2 rst_n = 1'b0;
        #1;
        check("arst_sp", bus_b.rd_data1, 32'd10000);
        check("arst_r7", bus_b.rd_data2, 32'd0);
        check("arst_any", 32'(bus_b.busy_any), 32'd0);
        cyc();
        rst_n = 1'b1; idle(); rd_addr1 = 5'd3;
        #1;
        check("arst_write_lost", bus_b.rd_data1, 32'd0);
        check("arst_write_lost_n", bus_n.rd_data1, 32'd0);

        // Randomized traffic
        for (int c = 0; c < 2000; c++) begin
            cyc();
            rd_addr1  = rnd_addr();
            rd_addr2  = rnd_addr();
            we        = 1'($urandom_range(0, 1));
            wr_addr   = rnd_addr();
            wr_data   = $urandom;
            wr_be     = 4'($urandom);
            busy_set  = ($urandom_range(0, 2) == 0);
            busy_addr = rnd_addr();
            flush     = ($urandom_range(0, 15) == 0);
        end
        cyc(); idle();
        repeat (2) cyc();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
